// File: rtl/mycpu_hazard_ctrl.sv
// rtl/mycpu_hazard_ctrl.sv - decode-stage scoreboard, forwarding selects and load-use stall
module mycpu_hazard_ctrl #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [AW-1:0]    id_dst,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             ds_allowin,
    input  logic             flush,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic             stall,
    output logic             id_allowin,
    output logic             ex_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    // Slot 1 = EX, slot 2 = MEM, slot 3 = WB
    logic          s1_v, s2_v, s3_v;
    logic [AW-1:0] s1_dst, s2_dst, s3_dst;
    logic          s1_wen, s2_wen, s3_wen;
    logic          s1_ld, s2_ld, s3_ld;

    logic m1_rs, m2_rs, m3_rs;
    logic m1_rt, m2_rt, m3_rt;
    logic issue;

    assign m1_rs = s1_v & s1_wen & (s1_dst == id_rs) & (id_rs != '0);
    assign m2_rs = s2_v & s2_wen & (s2_dst == id_rs) & (id_rs != '0);
    assign m3_rs = s3_v & s3_wen & (s3_dst == id_rs) & (id_rs != '0);
    assign m1_rt = s1_v & s1_wen & (s1_dst == id_rt) & (id_rt != '0);
    assign m2_rt = s2_v & s2_wen & (s2_dst == id_rt) & (id_rt != '0);
    assign m3_rt = s3_v & s3_wen & (s3_dst == id_rt) & (id_rt != '0);

    // A load in EX has no data yet: select regfile and let the stall cover it
    always_comb begin
        fwd_rs_sel = 2'd0;
        if (id_use_rs) begin
            if (m1_rs)      fwd_rs_sel = s1_ld ? 2'd0 : 2'd1;
            else if (m2_rs) fwd_rs_sel = 2'd2;
            else if (m3_rs) fwd_rs_sel = 2'd3;
        end
    end

    always_comb begin
        fwd_rt_sel = 2'd0;
        if (id_use_rt) begin
            if (m1_rt)      fwd_rt_sel = s1_ld ? 2'd0 : 2'd1;
            else if (m2_rt) fwd_rt_sel = 2'd2;
            else if (m3_rt) fwd_rt_sel = 2'd3;
        end
    end

    assign stall      = id_valid & s1_ld & ((id_use_rs & m1_rs) | (id_use_rt & m1_rt));
    assign id_allowin = ds_allowin & ~stall;
    assign issue      = id_valid & id_allowin;
    assign ex_valid   = s1_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush) begin
                s1_v <= 1'b0;
                s2_v <= 1'b0;
                s3_v <= 1'b0;
            end else if (ds_allowin) begin
                s3_v   <= s2_v;
                s3_dst <= s2_dst;
                s3_wen <= s2_wen;
                s3_ld  <= s2_ld;
                s2_v   <= s1_v;
                s2_dst <= s1_dst;
                s2_wen <= s1_wen;
                s2_ld  <= s1_ld;
                s1_v   <= issue;
                s1_dst <= id_dst;
                s1_wen <= id_wen;
                s1_ld  <= id_is_load;
            end
        end
    end

endmodule

// File: tb/tb_mycpu_hazard_ctrl.sv
// tb/tb_mycpu_hazard_ctrl.sv - directed self-checking bench for mycpu_hazard_ctrl
module tb_mycpu_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_use_rs, id_use_rt, id_wen, id_is_load;
    logic        ds_allowin, flush;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic        stall, id_allowin, ex_valid;
    logic [31:0] stall_cnt;
    logic [1:0]  s_fwd_rs_sel, s_fwd_rt_sel;
    logic        s_stall, s_id_allowin, s_ex_valid;
    logic [3:0]  s_stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mycpu_hazard_ctrl #(.AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_wen(id_wen),
        .id_is_load(id_is_load), .ds_allowin(ds_allowin), .flush(flush),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall(stall),
        .id_allowin(id_allowin), .ex_valid(ex_valid), .stall_cnt(stall_cnt)
    );

    mycpu_hazard_ctrl #(.AW(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_wen(id_wen),
        .id_is_load(id_is_load), .ds_allowin(ds_allowin), .flush(flush),
        .fwd_rs_sel(s_fwd_rs_sel), .fwd_rt_sel(s_fwd_rt_sel), .stall(s_stall),
        .id_allowin(s_id_allowin), .ex_valid(s_ex_valid), .stall_cnt(s_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] dst, input logic wen, input logic ld);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_dst = dst; id_wen = wen; id_is_load = ld;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; ds_allowin = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (fwd_rs_sel !== 2'd0) $display("FAIL reset_rs_sel got %0d exp 0", fwd_rs_sel); else passed++;
        total++; if (fwd_rt_sel !== 2'd0) $display("FAIL reset_rt_sel got %0d exp 0", fwd_rt_sel); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %b exp 0", ex_valid); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); else passed++;
        total++; if (id_allowin !== 1'b1) $display("FAIL reset_allowin_hi got %b exp 1", id_allowin); else passed++;
        ds_allowin = 1'b0; #1;
        total++; if (id_allowin !== 1'b0) $display("FAIL reset_allowin_lo got %b exp 0", id_allowin); else passed++;
        ds_allowin = 1'b1; #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 1, 1, 2, 1, 3, 1, 0);          // addu $3
        step();
        drive(1, 3, 1, 0, 0, 0, 0, 0);          // uses $3, writes nothing
        total++; if (fwd_rs_sel !== 2'd1) $display("FAIL b2b_ex got %0d exp 1", fwd_rs_sel); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL b2b_stall got %b exp 0", stall); else passed++;
        total++; if (ex_valid !== 1'b1) $display("FAIL b2b_ex_valid got %b exp 1", ex_valid); else passed++;
        total++; if (fwd_rt_sel !== 2'd0) $display("FAIL b2b_rt_unused got %0d exp 0", fwd_rt_sel); else passed++;
        step();
        total++; if (fwd_rs_sel !== 2'd2) $display("FAIL b2b_mem got %0d exp 2", fwd_rs_sel); else passed++;
        step();
        total++; if (fwd_rs_sel !== 2'd3) $display("FAIL b2b_wb got %0d exp 3", fwd_rs_sel); else passed++;
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        total++; if (fwd_rs_sel !== 2'd0) $display("FAIL b2b_not_used got %0d exp 0", fwd_rs_sel); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 1, 1, 0, 0, 5, 1, 1);          // lw $5
        step();
        drive(1, 0, 0, 5, 1, 6, 1, 0);
        total++; if (stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", stall); else passed++;
        total++; if (id_allowin !== 1'b0) $display("FAIL lu_allowin got %b exp 0", id_allowin); else passed++;
        total++; if (fwd_rt_sel !== 2'd0) $display("FAIL lu_rt_sel got %0d exp 0", fwd_rt_sel); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL lu_cnt0 got %0d exp 0", stall_cnt); else passed++;
        step();
        total++; if (stall_cnt !== 32'd1) $display("FAIL lu_cnt1 got %0d exp 1", stall_cnt); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL lu_stall_clear got %b exp 0", stall); else passed++;
        total++; if (fwd_rt_sel !== 2'd2) $display("FAIL lu_rt_mem got %0d exp 2", fwd_rt_sel); else passed++;
        total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble got %b exp 0", ex_valid); else passed++;
        total++; if (id_allowin !== 1'b1) $display("FAIL lu_allowin_back got %b exp 1", id_allowin); else passed++;
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (ex_valid !== 1'b1) $display("FAIL lu_issued got %b exp 1", ex_valid); else passed++;
    endtask

    task automatic test_zero_nowrite();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 1);          // lw $0
        step();
        drive(1, 0, 1, 0, 1, 7, 0, 0);          // store with dst=7, wen=0, reads $0
        total++; if (fwd_rs_sel !== 2'd0) $display("FAIL zero_rs got %0d exp 0", fwd_rs_sel); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL zero_stall got %b exp 0", stall); else passed++;
        step();
        drive(1, 7, 1, 7, 1, 0, 0, 0);
        total++; if (fwd_rs_sel !== 2'd0) $display("FAIL nowrite_rs got %0d exp 0", fwd_rs_sel); else passed++;
        total++; if (fwd_rt_sel !== 2'd0) $display("FAIL nowrite_rt got %0d exp 0", fwd_rt_sel); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL nowrite_stall got %b exp 0", stall); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 9, 1, 0);
            step();
        end
        drive(1, 9, 1, 9, 1, 0, 0, 0);
        total++; if (fwd_rs_sel !== 2'd1) $display("FAIL prio_s1 got %0d exp 1", fwd_rs_sel); else passed++;
        total++; if (fwd_rt_sel !== 2'd1) $display("FAIL prio_s1_rt got %0d exp 1", fwd_rt_sel); else passed++;
        drive(0, 9, 1, 9, 1, 0, 0, 0);
        step();
        total++; if (fwd_rs_sel !== 2'd2) $display("FAIL prio_s2 got %0d exp 2", fwd_rs_sel); else passed++;
        step();
        total++; if (fwd_rs_sel !== 2'd3) $display("FAIL prio_s3 got %0d exp 3", fwd_rs_sel); else passed++;
    endtask

    task automatic test_freeze_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1);          // lw $5
        step();
        drive(1, 5, 1, 5, 1, 8, 1, 0);          // rs==rt==5
        ds_allowin = 1'b0; #1;
        total++; if (stall !== 1'b1) $display("FAIL frz_stall got %b exp 1", stall); else passed++;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (stall !== 1'b1 || ex_valid !== 1'b1) $display("FAIL frz_hold%0d got stall=%b ex_valid=%b exp 1 1", i, stall, ex_valid); else passed++;
            total++; if (stall_cnt !== 32'(i)) $display("FAIL frz_cnt%0d got %0d exp %0d", i, stall_cnt, i); else passed++;
        end
        ds_allowin = 1'b1; flush = 1'b1; #1;
        step();
        flush = 1'b0; #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL flush_ex_valid got %b exp 0", ex_valid); else passed++;
        total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) $display("FAIL flush_sel got %0d/%0d exp 0/0", fwd_rs_sel, fwd_rt_sel); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL flush_stall got %b exp 0", stall); else passed++;
        total++; if (stall_cnt !== 32'd4) $display("FAIL flush_cnt got %0d exp 4", stall_cnt); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1);
        step();
        drive(1, 0, 0, 5, 1, 6, 1, 0);
        total++; if (stall !== 1'b1) $display("FAIL rms_stall got %b exp 1", stall); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        total++; if (stall !== 1'b0) $display("FAIL rms_stall_clear got %b exp 0", stall); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL rms_cnt got %0d exp 0", stall_cnt); else passed++;
        total++; if (id_allowin !== 1'b1) $display("FAIL rms_allowin got %b exp 1", id_allowin); else passed++;
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL rms_issue got %b exp 1", ex_valid); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1);
        step();
        drive(1, 5, 1, 0, 0, 6, 1, 0);
        ds_allowin = 1'b0; #1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                total++; if (s_stall_cnt !== 4'hE) $display("FAIL sat_pre got %h exp e", s_stall_cnt); else passed++;
            end
            if (i == 15) begin
                total++; if (s_stall_cnt !== 4'hF) $display("FAIL sat_reach got %h exp f", s_stall_cnt); else passed++;
            end
        end
        total++; if (s_stall_cnt !== 4'hF) $display("FAIL sat_hold got %h exp f", s_stall_cnt); else passed++;
        total++; if (stall_cnt !== 32'd20) $display("FAIL sat_wide got %0d exp 20", stall_cnt); else passed++;
        ds_allowin = 1'b1; #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ds_allowin = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_dst = 0; id_wen = 0; id_is_load = 0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_zero_nowrite();
        test_priority();
        test_freeze_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mycpu_hazard_ctrl.md
Name: mycpu_hazard_ctrl

Overview:
- Scoreboard and hazard controller that sequences the decode stage of the 5-stage MIPS pipeline.
- Tracks destination register, write-enable and load flag of the in-flight instructions in EX, MEM and WB.
- Produces per-operand forwarding selects and the load-use stall / allowin handshake for the decode stage.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- AW, 5, register address width.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- id_valid  input  1  decode stage holds a valid instruction
- id_rs  input  AW  rs field of the instruction in decode
- id_rt  input  AW  rt field of the instruction in decode
- id_use_rs  input  1  decode instruction reads rs
- id_use_rt  input  1  decode instruction reads rt
- id_dst  input  AW  destination register of the decode instruction
- id_wen  input  1  decode instruction writes the register file
- id_is_load  input  1  decode instruction is a load (lb/lbu/lh/lhu/lw/lwl/lwr)
- ds_allowin  input  1  downstream (EX) can accept; 0 freezes the scoreboard
- flush  input  1  exception/redirect flush; kills all tracked instructions
- fwd_rs_sel  output  2  0 regfile, 1 EX result, 2 MEM result, 3 WB result
- fwd_rt_sel  output  2  same encoding as fwd_rs_sel, for rt
- stall  output  1  load-use hazard; decode must insert a bubble
- id_allowin  output  1  decode may hand its instruction to EX this cycle
- ex_valid  output  1  EX slot holds a valid instruction (mirror for EX stage)
- stall_cnt  output  CNT_W  count of cycles with stall=1, saturating

Behaviour:
- Scoreboard: three slots S1 (EX), S2 (MEM), S3 (WB), each holding {v, dst, wen, ld}.
- A slot "writes r" iff v & wen & dst==r & r!=0. Register 0 never matches and never forwards or stalls.
- Forwarding select for an operand (rs shown; rt identical with id_rt/id_use_rt):
  - If !id_use_rs or no match: 0.
  - Else the youngest matching slot wins: S1 -> 1, else S2 -> 2, else S3 -> 3.
  - If S1 matches with ld=1: the select is 0 and the stall condition applies.
- stall = id_valid & ((id_use_rs & S1 writes id_rs & S1.ld) | (id_use_rt & S1 writes id_rt & S1.ld)).
  - Load data is first forwardable from MEM (select 2).
- id_allowin = ds_allowin & ~stall. When id_valid=0, id_allowin = ds_allowin.
- issue = id_valid & id_allowin.
- fwd_*_sel, stall, id_allowin and ex_valid are combinational from the current slots and decode inputs. No added latency.
- ex_valid = S1.v.
- Clock edge update, in priority order:
  - rst: all v<=0, stall_cnt<=0.
  - else flush: all v<=0. stall_cnt still counts if stall=1 this cycle. flush overrides ds_allowin.
  - else ds_allowin=0: all slots hold.
  - else (advance): S3<=S2, S2<=S1, S1<={1,id_dst,id_wen,id_is_load} if issue, else a bubble (v=0).
- A stalled instruction stays in decode and re-evaluates the next cycle. After exactly one bubble the load reaches S2 and the select becomes 2.
- stall_cnt increments on every non-reset cycle with stall=1, including while ds_allowin=0. It saturates at all-ones.
- After reset (empty scoreboard): selects 0, stall 0, ex_valid 0, id_allowin=ds_allowin, stall_cnt 0.
- Reset asserted mid-stall: the next cycle has an empty scoreboard. The stall clears and the pending decode instruction issues if still valid.
- rs==rt with both used: both selects are computed identically; a single stall.
- Multiple slots matching the same register: the youngest wins (S1 beats S2 beats S3).

Test Plan:
- Back-to-back ALU: addu $3 issued, next cycle decode uses rs=3 -> fwd_rs_sel=1, stall=0. Following two cycles, an instruction using $3 with nothing newer -> sel=2, then sel=3.
- Load-use: lw $5 issued, next decode uses rt=5 -> stall=1, id_allowin=0, stall_cnt 0->1. Next cycle stall=0, fwd_rt_sel=2, issue occurs.
- $0 and no-write: decode uses rs=0 after an instruction with dst=0; and rs=7 after a store (wen=0, dst=7) -> selects 0, stall 0.
- Priority: S1,S2,S3 all write $9 (S1 non-load) -> fwd_rs_sel=1. Same with S1.v=0 -> fwd_rs_sel=2.
- Freeze/flush: ds_allowin=0 for 3 cycles with the lw in S1 -> slots hold, stall stays 1, stall_cnt +3. Then flush=1 -> next cycle ex_valid=0, all selects 0, stall 0.
- Reset mid-stall and saturation: assert rst during a stall -> next cycle stall_cnt=0, stall=0. Preload stall_cnt to all-ones in CNT_W=4 build, stall again -> stays 4'hF.
